// File: rtl/reg_display_sequencer_if.sv
// reg_display_sequencer_if: register-file read port plus the character-plotter
// valid/ready handshake driven by the sequencer.
interface reg_display_sequencer_if;
    logic [8:0]  addr;
    logic [31:0] register_value;
    logic        char_valid;
    logic        char_ready;
    logic [3:0]  char_code;
    logic [2:0]  char_col;
    logic [8:0]  char_row;
    modport master (
        output addr, char_valid, char_code, char_col, char_row,
        input  register_value, char_ready
    );
    modport slave (
        input  addr, char_valid, char_code, char_col, char_row,
        output register_value, char_ready
    );
endinterface

// File: rtl/reg_display_sequencer.sv
// reg_display_sequencer: scans NUM_REGS registers and emits each as eight hex
// digits (MSB first) to a character plotter, one screen row per register.
module reg_display_sequencer #(
    parameter int NUM_REGS = 16,
    parameter int ROW_BASE = 0
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic start,
    output logic finished_register,
    output logic busy,
    output logic done,
    reg_display_sequencer_if.master bus
);
    typedef enum logic [2:0] {IDLE, FETCH, LATCH, EMIT, NEXT} state_t;
    localparam logic [8:0] LAST = 9'(NUM_REGS - 1);
    localparam logic [8:0] BASE = 9'(ROW_BASE);
    state_t      state_q, state_d;
    logic [8:0]  addr_q, addr_d;
    logic [31:0] shadow_q, shadow_d;
    logic [2:0]  idx_q, idx_d;
    logic        done_q, done_d;
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            shadow_q <= '0;
            idx_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
        end
    end
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        shadow_d = shadow_q;
        idx_d    = idx_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = FETCH;
                addr_d  = '0;
            end
            FETCH: state_d = LATCH;
            LATCH: begin
                shadow_d = bus.register_value;
                idx_d    = '0;
                state_d  = EMIT;
            end
            EMIT: if (bus.char_ready) begin
                idx_d   = idx_q + 3'd1;
                state_d = idx_q == 3'd7 ? NEXT : EMIT;
            end
            NEXT: if (addr_q == LAST) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end else begin
                addr_d  = addr_q + 9'd1;
                state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
    end
    // digit idx sits at bit 4*(7-idx); ~idx is 7-idx for a 3-bit index
    assign bus.char_code      = 4'(shadow_q >> {~idx_q, 2'b00});
    assign bus.char_col       = idx_q;
    assign bus.char_row       = BASE + addr_q;
    assign bus.char_valid     = state_q == EMIT;
    assign bus.addr           = addr_q;
    assign finished_register  = state_q == NEXT;
    assign busy               = state_q != IDLE;
    assign done               = done_q;
endmodule

// File: tb/tb_reg_display_sequencer.sv
// tb_reg_display_sequencer: randomized passes checked every cycle against a
// timeline/scoreboard model, plus literal pins for the fixed scenarios.
module tb_reg_display_sequencer;
    typedef struct packed {logic [3:0] code; logic [2:0] col; logic [8:0] row;} dig_t;
    localparam int NA = 2;
    logic clk = 1'b0;
    logic rst;
    logic start_a, start_b;
    logic fin_a, busy_a, done_a, fin_b, busy_b, done_b;
    logic [31:0] mem_a [0:511];
    logic [31:0] mem_b [0:511];
    int n_cmp = 0;
    int n_bad = 0;
    longint cyc = 0;
    reg_display_sequencer_if bus_a();
    reg_display_sequencer_if bus_b();
    reg_display_sequencer #(.NUM_REGS(NA), .ROW_BASE(0)) dut_a (
        .CLOCK_50(clk), .reset(rst), .start(start_a),
        .finished_register(fin_a), .busy(busy_a), .done(done_a), .bus(bus_a)
    );
    reg_display_sequencer #(.NUM_REGS(1), .ROW_BASE(5)) dut_b (
        .CLOCK_50(clk), .reset(rst), .start(start_b),
        .finished_register(fin_b), .busy(busy_b), .done(done_b), .bus(bus_b)
    );
    always #5 clk = ~clk;
    // synchronous-read register files: data valid one cycle after addr
    always @(posedge clk) begin
        cyc <= cyc + 1;
        bus_a.register_value <= mem_a[bus_a.addr];
        bus_b.register_value <= mem_b[bus_b.addr];
    end
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask
    // model of DUT A: pass timeline in cycles plus a queue of expected digits
    dig_t   exp_q[$];
    dig_t   log_q[$];
    longint fin_log[$];
    longint done_log[$];
    longint start_cyc = 0;
    int     m_gap = 0, m_dig = 0, m_reg = 0;
    bit     m_busy = 0, m_fin = 0, m_done = 0;
    logic   p_valid = 1'b0, p_ready = 1'b0;
    dig_t   p_dig;
    always @(negedge clk) begin
        dig_t cur;
        bit   nd;
        cur = {bus_a.char_code, bus_a.char_col, bus_a.char_row};
        if (rst) begin
            chk("rst_valid", 64'(bus_a.char_valid), 0);
            chk("rst_digit", 64'(cur), 0);
            chk("rst_flags", 64'({fin_a, busy_a, done_a}), 0);
            chk("rst_addr", 64'(bus_a.addr), 0);
            exp_q.delete();
            {m_busy, m_fin, m_done} = 3'b000;
            m_gap = 0; m_dig = 0; m_reg = 0;
            p_valid = 1'b0;
        end else begin
            chk("valid", 64'(bus_a.char_valid), 64'(m_busy && !m_fin && m_gap == 0));
            chk("finished", 64'(fin_a), 64'(m_fin));
            chk("done", 64'(done_a), 64'(m_done));
            chk("busy", 64'(busy_a), 64'(m_busy));
            chk("addr", 64'(bus_a.addr), 64'(m_reg));
            if (bus_a.char_valid && exp_q.size() > 0) chk("digit", 64'(cur), 64'(exp_q[0]));
            if (p_valid && !p_ready) chk("stall_hold", 64'({bus_a.char_valid, cur}), 64'({1'b1, p_dig}));
            if (fin_a) fin_log.push_back(cyc - start_cyc);
            if (done_a) done_log.push_back(cyc - start_cyc);
            if (bus_a.char_valid && bus_a.char_ready) log_q.push_back(cur);
            p_valid = bus_a.char_valid;
            p_ready = bus_a.char_ready;
            p_dig   = cur;
            nd = 0;
            if (m_fin) begin
                m_fin = 0;
                if (m_reg == NA - 1) begin m_busy = 0; nd = 1; end
                else begin m_reg++; m_gap = 2; end
            end else if (m_busy) begin
                if (m_gap > 0) m_gap--;
                else if (bus_a.char_ready) begin
                    void'(exp_q.pop_front());
                    m_dig++;
                    if (m_dig == 8) begin m_dig = 0; m_fin = 1; end
                end
            end else if (start_a) begin
                m_busy = 1; m_gap = 2; m_reg = 0; start_cyc = cyc;
                exp_q.delete();
                for (int r = 0; r < NA; r++)
                    for (int d = 0; d < 8; d++)
                        exp_q.push_back({4'(mem_a[r] >> (28 - 4 * d)), 3'(d), 9'(r)});
            end
            m_done = nd;
        end
    end
    task automatic clear_logs();
        log_q.delete(); fin_log.delete(); done_log.delete();
    endtask
    task automatic pulse_a();
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
    endtask
    task automatic wait_pass(input bit rnd);
        int k = 0;
        while ((m_busy || m_done) && k < 2000) begin
            @(posedge clk); #1;
            k++;
            if (rnd) begin
                bus_a.char_ready = 1'($urandom_range(0, 1));
                start_a = m_busy && !m_fin && $urandom_range(0, 3) == 0;
                if (m_busy && !m_fin && m_gap == 0) mem_a[m_reg] = $urandom;
            end
        end
        start_a = 1'b0;
        chk("pass_end", 64'(m_busy || m_done), 0);
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        logic [63:0] lit;
        int k;
        for (int i = 0; i < 512; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        bus_a.char_ready = 1'b0; bus_b.char_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        // fixed two-register pass, ready tied high
        mem_a[0] = 32'h12345678; mem_a[1] = 32'hDEADBEEF;
        bus_a.char_ready = 1'b1;
        clear_logs();
        pulse_a();
        wait_pass(0);
        lit = 64'h12345678DEADBEEF;
        chk("t1_count", 64'(log_q.size()), 16);
        for (int i = 0; i < 16 && i < log_q.size(); i++)
            chk($sformatf("t1_dig%0d", i), 64'(log_q[i]), 64'({4'(lit >> (60 - 4 * i)), 3'(i % 8), 9'(i / 8)}));
        chk("t1_fin_n", 64'(fin_log.size()), 2);
        chk("t1_fin0", fin_log.size() > 0 ? fin_log[0] : -1, 11);
        chk("t1_fin1", fin_log.size() > 1 ? fin_log[1] : -1, 22);
        chk("t1_done_n", 64'(done_log.size()), 1);
        chk("t1_done", done_log.size() > 0 ? done_log[0] : -1, 23);
        // random stalls, start re-pulses while busy, register_value churn during emit
        for (int p = 0; p < 6; p++) begin
            mem_a[0] = $urandom; mem_a[1] = $urandom;
            clear_logs();
            pulse_a();
            wait_pass(1);
            chk("rnd_done_once", 64'(done_log.size()), 1);
            chk("rnd_digits", 64'(log_q.size()), 16);
            chk("rnd_drained", 64'(exp_q.size()), 0);
        end
        // reset at the third digit of reg1
        bus_a.char_ready = 1'b1;
        mem_a[0] = 32'hCAFEF00D; mem_a[1] = 32'h0BADBEEF;
        clear_logs();
        pulse_a();
        k = 0;
        while (!(m_busy && !m_fin && m_gap == 0 && m_reg == 1 && m_dig == 2) && k < 500) begin
            @(posedge clk); #1 k++;
        end
        chk("rst_reach", 64'(k < 500), 1);
        @(negedge clk); #2 rst = 1'b1;
        #1;
        chk("arst_valid", 64'(bus_a.char_valid), 0);
        chk("arst_code", 64'(bus_a.char_code), 0);
        chk("arst_col", 64'(bus_a.char_col), 0);
        chk("arst_row", 64'(bus_a.char_row), 0);
        chk("arst_addr", 64'(bus_a.addr), 0);
        chk("arst_fin", 64'(fin_a), 0);
        chk("arst_busy", 64'(busy_a), 0);
        chk("arst_done", 64'(done_a), 0);
        repeat (2) @(posedge clk);
        @(negedge clk); #2 rst = 1'b0;
        repeat (6) @(posedge clk);
        chk("rst_no_done", 64'(done_log.size()), 0);
        clear_logs();
        pulse_a();
        wait_pass(0);
        chk("rst_restart_digits", 64'(log_q.size()), 16);
        chk("rst_restart_first", 64'(log_q.size() > 0 ? log_q[0] : '1), 64'({4'hC, 3'd0, 9'd0}));
        chk("rst_restart_done", 64'(done_log.size()), 1);
        // single register of zeros, ROW_BASE 5
        mem_b[0] = 32'h0;
        bus_b.char_ready = 1'b1;
        @(posedge clk); #1 start_b = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            chk($sformatf("b_valid%0d", c), 64'(bus_b.char_valid), 64'(c >= 3 && c <= 10));
            chk($sformatf("b_fin%0d", c), 64'(fin_b), 64'(c == 11));
            chk($sformatf("b_done%0d", c), 64'(done_b), 64'(c == 12));
            chk($sformatf("b_busy%0d", c), 64'(busy_b), 64'(c >= 1 && c <= 11));
            if (c >= 3 && c <= 10)
                chk($sformatf("b_dig%0d", c), 64'({bus_b.char_code, bus_b.char_col, bus_b.char_row}),
                    64'({4'h0, 3'(c - 3), 9'd5}));
            @(posedge clk); #1 start_b = 1'b0;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
